// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared widths, encodings and helpers for the traffic light controller
package tlc_pkg;

  localparam int MIN_W       = 11;
  localparam int DAY_MINUTES = 1440;

  // 2'b11 is treated the same as FORCE_AUTO
  typedef enum logic [1:0] {
    FORCE_AUTO = 2'b00,
    FORCE_OFF  = 2'b01,
    FORCE_PEAK = 2'b10
  } peak_force_t;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2
  } light_t;

  // Half-open window; start >= end never matches
  function automatic logic in_window(input logic [MIN_W-1:0] m,
                                     input logic [MIN_W-1:0] lo,
                                     input logic [MIN_W-1:0] hi);
    return (m >= lo) && (m < hi);
  endfunction

endpackage

// File: rtl/tlc_input_conditioner_if.sv
// rtl/tlc_input_conditioner_if.sv - raw sensor/time-of-day inputs and conditioned outputs
interface tlc_input_conditioner_if;
  import tlc_pkg::*;

  logic             sensor1_raw;
  logic             sensor2_raw;
  logic             tod_load;
  logic [MIN_W-1:0] tod_value;
  logic [1:0]       peak_force;
  logic             sensor1;
  logic             sensor2;
  logic             peak;
  logic [MIN_W-1:0] minute_of_day;
  logic             minute_tick;

  modport master (
    output sensor1_raw, sensor2_raw, tod_load, tod_value, peak_force,
    input  sensor1, sensor2, peak, minute_of_day, minute_tick
  );

  modport slave (
    input  sensor1_raw, sensor2_raw, tod_load, tod_value, peak_force,
    output sensor1, sensor2, peak, minute_of_day, minute_tick
  );

endinterface

// File: rtl/tlc_debounce.sv
// rtl/tlc_debounce.sv - two-flop synchroniser plus stable-count debouncer for one loop sensor
module tlc_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  localparam int             CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == clean) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // This edge would make the count reach DEB_CYCLES: accept the new level
        clean <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlc_input_conditioner.sv
// rtl/tlc_input_conditioner.sv - debounced sensors, minute-of-day clock and peak flag for the controller
module tlc_input_conditioner #(
  parameter int TICKS_PER_MIN = 60,
  parameter int DEB_CYCLES    = 4,
  parameter int DAY_MINUTES   = 1440,
  parameter int INIT_MINUTE   = 0,
  parameter int AM_START      = 420,
  parameter int AM_END        = 600,
  parameter int PM_START      = 1020,
  parameter int PM_END        = 1200
) (
  input  logic                     clk,
  input  logic                     reset,
  tlc_input_conditioner_if.slave   bus
);
  import tlc_pkg::MIN_W;
  import tlc_pkg::in_window;
  import tlc_pkg::FORCE_OFF;
  import tlc_pkg::FORCE_PEAK;

  localparam int               PW       = $clog2(TICKS_PER_MIN);
  localparam logic [PW-1:0]    PRE_LAST = PW'(TICKS_PER_MIN - 1);
  localparam logic [MIN_W-1:0] DAY_M    = MIN_W'(DAY_MINUTES);
  localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(DAY_MINUTES - 1);
  localparam logic [MIN_W-1:0] MIN_INIT = MIN_W'(INIT_MINUTE);
  localparam logic [MIN_W-1:0] AM_S     = MIN_W'(AM_START);
  localparam logic [MIN_W-1:0] AM_E     = MIN_W'(AM_END);
  localparam logic [MIN_W-1:0] PM_S     = MIN_W'(PM_START);
  localparam logic [MIN_W-1:0] PM_E     = MIN_W'(PM_END);

  logic             s1_clean;
  logic             s2_clean;
  logic [PW-1:0]    presc;
  logic [MIN_W-1:0] minute;
  logic             tick;
  logic             peak_q;
  logic             peak_next;

  tlc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb1 (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.sensor1_raw),
    .clean (s1_clean)
  );

  tlc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb2 (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.sensor2_raw),
    .clean (s2_clean)
  );

  // A load overrides a coincident prescaler wrap and suppresses that tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc  <= '0;
      minute <= MIN_INIT;
      tick   <= 1'b0;
    end else if (bus.tod_load) begin
      presc  <= '0;
      tick   <= 1'b0;
      minute <= (bus.tod_value >= DAY_M) ? '0 : bus.tod_value;
    end else if (presc == PRE_LAST) begin
      presc  <= '0;
      tick   <= 1'b1;
      minute <= (minute == MIN_LAST) ? '0 : minute + 1'b1;
    end else begin
      presc  <= presc + 1'b1;
      tick   <= 1'b0;
    end
  end

  always_comb begin
    peak_next = in_window(minute, AM_S, AM_E) || in_window(minute, PM_S, PM_E);
    case (bus.peak_force)
      FORCE_PEAK: peak_next = 1'b1;
      FORCE_OFF:  peak_next = 1'b0;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_q <= 1'b0;
    end else begin
      peak_q <= peak_next;
    end
  end

  assign bus.sensor1       = s1_clean;
  assign bus.sensor2       = s2_clean;
  assign bus.peak          = peak_q;
  assign bus.minute_of_day = minute;
  assign bus.minute_tick   = tick;

endmodule

// File: tb/tb_tlc_input_conditioner.sv
// tb/tb_tlc_input_conditioner.sv - self-checking bench for tlc_input_conditioner
module tb_tlc_input_conditioner;

  localparam int T    = 4;
  localparam int DEB  = 3;
  localparam int DAYM = 1440;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tlc_input_conditioner_if bus();

  tlc_input_conditioner #(.TICKS_PER_MIN(T), .DEB_CYCLES(DEB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: minute from elapsed cycles, sensors from a sliding window of raw samples
  int m_base, m_cyc, m_min, m_tick, m_peak;
  int m_out [2];
  int hist  [2][32];
  int hn;

  function automatic int peak_rule(input int m, input int f);
    if (f == 2) return 1;
    if (f == 1) return 0;
    return ((m >= 420 && m < 600) || (m >= 1020 && m < 1200)) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_base = 0; m_cyc = 0; m_min = 0; m_tick = 0; m_peak = 0;
    m_out[0] = 0; m_out[1] = 0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 32; k++) hist[i][k] = 0;
    hn = 32;
  endtask

  task automatic model_edge();
    int all;
    m_peak = peak_rule(m_min, int'(bus.peak_force));
    hist[0][hn % 32] = int'(bus.sensor1_raw);
    hist[1][hn % 32] = int'(bus.sensor2_raw);
    for (int i = 0; i < 2; i++) begin
      all = 1;
      // the debouncer sees raw samples two edges old (synchroniser delay)
      for (int j = 2; j <= DEB + 1; j++)
        if (hist[i][(hn - j) % 32] == m_out[i]) all = 0;
      if (all == 1) m_out[i] = 1 - m_out[i];
    end
    hn++;
    if (bus.tod_load) begin
      m_base = (int'(bus.tod_value) >= DAYM) ? 0 : int'(bus.tod_value);
      m_cyc  = 0;
      m_tick = 0;
      m_min  = m_base;
    end else begin
      m_cyc++;
      m_tick = (m_cyc % T == 0) ? 1 : 0;
      m_min  = (m_base + m_cyc / T) % DAYM;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic load(input int v);
    bus.tod_load  = 1'b1;
    bus.tod_value = 11'(v);
    step();
    bus.tod_load  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sensor1"}, int'(bus.sensor1), 0);
    chk({tag, "_sensor2"}, int'(bus.sensor2), 0);
    chk({tag, "_peak"},    int'(bus.peak), 0);
    chk({tag, "_tick"},    int'(bus.minute_tick), 0);
    chk({tag, "_minute"},  int'(bus.minute_of_day), 0);
  endtask

  typedef struct {
    int val;
    int force_sel;
    int exp_min;
    int exp_peak;
  } vec_t;

  vec_t tbl [14];
  int ticks;

  initial begin
    bus.sensor1_raw = 1'b0;
    bus.sensor2_raw = 1'b0;
    bus.tod_load    = 1'b0;
    bus.tod_value   = '0;
    bus.peak_force  = 2'b00;
    model_reset();

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;
    model_reset();

    // Short pulse ignored, long pulse passes with DEB+2 edge latency
    bus.sensor1_raw = 1'b1;
    step(); step();
    bus.sensor1_raw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("short_pulse_sensor1", int'(bus.sensor1), 0);
    end
    bus.sensor1_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 4) chk("rise_edge4_sensor1", int'(bus.sensor1), 0);
      if (k == 5) chk("rise_edge5_sensor1", int'(bus.sensor1), 1);
      chk("rise_sensor2", int'(bus.sensor2), 0);
    end
    bus.sensor1_raw = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 4) chk("fall_edge4_sensor1", int'(bus.sensor1), 1);
      if (k == 5) chk("fall_edge5_sensor1", int'(bus.sensor1), 0);
      chk("fall_sensor2", int'(bus.sensor2), 0);
    end

    // Entering and leaving the morning window
    load(419);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("am_pre_tick", int'(bus.minute_tick), 0);
      chk("am_pre_peak", int'(bus.peak), 0);
    end
    step();
    chk("am_enter_minute", int'(bus.minute_of_day), 420);
    chk("am_enter_tick",   int'(bus.minute_tick), 1);
    chk("am_enter_peak_lag", int'(bus.peak), 0);
    step();
    chk("am_enter_peak", int'(bus.peak), 1);
    chk("am_tick_one_cycle", int'(bus.minute_tick), 0);
    load(599);
    repeat (4) step();
    chk("am_exit_minute", int'(bus.minute_of_day), 600);
    chk("am_exit_peak_lag", int'(bus.peak), 1);
    step();
    chk("am_exit_peak", int'(bus.peak), 0);

    // Day wrap and out-of-range load
    load(1439);
    ticks = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      ticks += int'(bus.minute_tick);
    end
    chk("wrap_minute", int'(bus.minute_of_day), 0);
    chk("wrap_ticks", ticks, 1);
    load(2000);
    chk("load_oob_minute", int'(bus.minute_of_day), 0);

    // Manual override
    bus.peak_force = 2'b10;
    step();
    chk("force_peak", int'(bus.peak), 1);
    bus.peak_force = 2'b01;
    load(480);
    step();
    chk("force_off", int'(bus.peak), 0);
    bus.peak_force = 2'b00;
    step();
    chk("force_auto", int'(bus.peak), 1);

    // Load coinciding with prescaler wrap
    load(1000);
    repeat (3) step();
    load(1019);
    chk("coincide_minute", int'(bus.minute_of_day), 1019);
    chk("coincide_tick", int'(bus.minute_tick), 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("coincide_no_tick", int'(bus.minute_tick), 0);
    end
    step();
    chk("coincide_next_minute", int'(bus.minute_of_day), 1020);
    chk("coincide_next_tick", int'(bus.minute_tick), 1);
    step();
    chk("coincide_peak", int'(bus.peak), 1);

    // Window boundaries and force decoding
    tbl[0]  = '{419, 0, 419, 0};
    tbl[1]  = '{420, 0, 420, 1};
    tbl[2]  = '{599, 0, 599, 1};
    tbl[3]  = '{600, 0, 600, 0};
    tbl[4]  = '{1019, 0, 1019, 0};
    tbl[5]  = '{1020, 0, 1020, 1};
    tbl[6]  = '{1199, 0, 1199, 1};
    tbl[7]  = '{1200, 0, 1200, 0};
    tbl[8]  = '{2000, 0, 0, 0};
    tbl[9]  = '{480, 1, 480, 0};
    tbl[10] = '{0, 2, 0, 1};
    tbl[11] = '{1439, 3, 1439, 0};
    tbl[12] = '{450, 3, 450, 1};
    tbl[13] = '{1440, 2, 0, 1};
    for (int i = 0; i < 14; i++) begin
      bus.peak_force = 2'(tbl[i].force_sel);
      load(tbl[i].val);
      step();
      chk($sformatf("tbl%0d_minute", i), int'(bus.minute_of_day), tbl[i].exp_min);
      chk($sformatf("tbl%0d_peak", i),   int'(bus.peak), tbl[i].exp_peak);
    end

    // Asynchronous reset in the middle of activity
    bus.peak_force  = 2'b10;
    bus.sensor1_raw = 1'b1;
    load(500);
    repeat (6) step();
    chk("pre_reset_sensor1", int'(bus.sensor1), 1);
    chk("pre_reset_peak",    int'(bus.peak), 1);
    #2 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    bus.sensor1_raw = 1'b0;
    bus.peak_force  = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // Randomised run against the reference model
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 5) == 0) bus.sensor1_raw = ~bus.sensor1_raw;
      if ($urandom_range(0, 5) == 0) bus.sensor2_raw = ~bus.sensor2_raw;
      bus.tod_load  = ($urandom_range(0, 49) == 0);
      bus.tod_value = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 39) == 0) bus.peak_force = 2'($urandom_range(0, 3));
      step();
      chk("rnd_sensor1", int'(bus.sensor1), m_out[0]);
      chk("rnd_sensor2", int'(bus.sensor2), m_out[1]);
      chk("rnd_peak",    int'(bus.peak), m_peak);
      chk("rnd_minute",  int'(bus.minute_of_day), m_min);
      chk("rnd_tick",    int'(bus.minute_tick), m_tick);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tlc_input_conditioner.md
Name: tlc_input_conditioner

Overview:
- Upstream stage of the traffic light controller. Produces its clean sensor1, sensor2 and peak inputs.
- Synchronises and debounces the two raw vehicle-loop sensors.
- Keeps a minute-of-day clock and derives peak/off-peak from two configurable daily windows, with a manual override.
- All outputs are registered, so the controller sees glitch-free, clock-aligned levels.

Parameters:
TICKS_PER_MIN, 60, clk cycles per minute (prescaler modulus, >=2)
DEB_CYCLES, 4, consecutive stable cycles needed before a debounced sensor changes (>=1)
DAY_MINUTES, 1440, minute counter modulus
INIT_MINUTE, 0, minute_of_day value after reset
AM_START, 420, morning peak window start (inclusive)
AM_END, 600, morning peak window end (exclusive)
PM_START, 1020, evening peak window start (inclusive)
PM_END, 1200, evening peak window end (exclusive)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
sensor1_raw  in  1  raw loop sensor, direction 1, asynchronous
sensor2_raw  in  1  raw loop sensor, direction 2, asynchronous
tod_load  in  1  synchronous load strobe for minute_of_day
tod_value  in  11  minute value to load
peak_force  in  2  00/11 auto, 01 force off-peak, 10 force peak
sensor1  out  1  debounced sensor 1 (to controller)
sensor2  out  1  debounced sensor 2 (to controller)
peak  out  1  peak-mode flag (to controller)
minute_of_day  out  11  current minute, 0..DAY_MINUTES-1
minute_tick  out  1  one-cycle pulse on every minute increment

Behaviour:
- Reset (reset=0, async):
  - sensor1, sensor2, peak and minute_tick go to 0.
  - minute_of_day goes to INIT_MINUTE.
  - Synchroniser flops, debounce counters and the prescaler go to 0.
  - Reset may assert at any cycle; all state clears immediately.
- Synchroniser: two flops per raw sensor. s2 is the synchronised value.
- Debounce, per sensor:
  - cnt increments on each edge where s2 != out.
  - On the edge where cnt would reach DEB_CYCLES, out takes s2 and cnt clears.
  - Any edge with s2 == out clears cnt.
  - Latency: raw change held stable is visible at the (DEB_CYCLES+2)th rising edge after the change.
  - Pulses shorter than DEB_CYCLES cycles at s2 are ignored.
- Prescaler:
  - Counts 0..TICKS_PER_MIN-1.
  - On the wrap edge, minute_tick is set to 1 for exactly one cycle and minute_of_day increments.
  - At DAY_MINUTES-1, minute_of_day wraps to 0.
- tod_load (priority over increment):
  - minute_of_day <= tod_value, or 0 if tod_value >= DAY_MINUTES.
  - Prescaler clears to 0 and minute_tick is 0 that cycle.
  - If load and prescaler wrap coincide, the load wins and no tick is issued.
- peak, registered each edge from the current registered minute_of_day (one-cycle lag after the minute changes):
  - peak_force=10: 1.
  - peak_force=01: 0.
  - Otherwise: (AM_START<=m<AM_END) || (PM_START<=m<PM_END).
  - Windows are half-open. An empty window (start>=end) never matches.
  - peak_force changes take effect at the next edge.
- Width rules: minute comparisons are unsigned 11-bit. The prescaler width is clog2(TICKS_PER_MIN). The debounce counter width is clog2(DEB_CYCLES+1).

Decomposition:
- Shared package tlc_pkg holds:
  - MIN_W=11 and DAY_MINUTES.
  - peak_force encodings (FORCE_AUTO, FORCE_OFF, FORCE_PEAK).
  - Light colour encoding (GREEN=0, YELLOW=1, RED=2), also used by the controller.
- One sub-module, tlc_debounce (synchroniser + debounce counter, parameter DEB_CYCLES), instantiated twice.

Test Plan (bench overrides TICKS_PER_MIN=4, DEB_CYCLES=3):
1. Reset released, then reset=0 driven mid-run for 1 cycle -> all outputs 0 and minute_of_day=0 immediately, before any clock edge.
2. sensor1_raw=1 for 2 cycles -> sensor1 stays 0. sensor1_raw=1 for 10 cycles -> sensor1=1 at the 5th edge after the rise, back to 0 at the 5th edge after the fall. sensor2 stays 0 throughout.
3. Load 419 with auto mode -> peak=0. After 4 edges minute_of_day=420 and minute_tick=1; peak=1 one edge later. Load 599, then run 4 edges -> minute 600, peak=0 one edge later.
4. Load 1439, run 4 edges -> minute_of_day=0 with a single minute_tick pulse. Load 2000 -> minute_of_day=0.
5. At minute 0, peak_force=10 -> peak=1 next edge. Load 480 with peak_force=01 -> peak=0. Return to 00 -> peak=1.
6. Assert tod_load=1 with tod_value=1019 on the same edge the prescaler is at 3 -> minute_of_day=1019, minute_tick=0, prescaler=0. The next tick arrives 4 edges later (minute 1020), with peak=1 one edge after that.
